range_lock_detector: RTL
========================

RANGE_LOCK_DETECTOR -- requirements
Module: range_lock_detector

Interface
REQ-001 Parameter W, default 16: signed sample and center width in bits, W >= 4.
REQ-002 Parameter N, default 4: number of range channels, N >= 1.
REQ-003 Parameter HOLD, default 8: consecutive valid hits required to lock, HOLD >= 1.
REQ-004 Parameter RELEASE, default 4: consecutive valid misses required to unlock, RELEASE >= 1.
REQ-005 clk  input  1: single clock; all state is updated on the rising edge.
REQ-006 resetn  input  1: reset, asynchronous and active-low.
REQ-007 in_valid  input  1: qualifies x for one cycle.
REQ-008 x  input  W: signed sample.
REQ-009 centers  input  N*W: signed channel centers, packed; channel i occupies bits [i*W +: W].
REQ-010 tol  input  W: unsigned tolerance, shared by all channels, quasi-static.
REQ-011 out_valid  output  1: in_range is valid for the sample.
REQ-012 in_range  output  N: per-channel hit flags for the sample.
REQ-013 locked  output  1: lock status.
REQ-014 lock_idx  output  max(1,clog2(N)): locked or candidate channel index.

Function
REQ-015 The block SHALL flag channel i as hit when centers[i]-tol <= x <= centers[i]+tol, with both bounds inclusive.
REQ-016 The block SHALL compute the bounds and comparisons at W+2 bits signed, so there is no wrap-around at extreme centers or tolerance.
REQ-017 Stage 1 SHALL register in_range and out_valid one cycle after in_valid: in_range is all zeros, out_valid=0 when no sample is present.
REQ-018 The block SHALL select the lowest-index hit as the "first hit"; the first hit is undefined when no channel hits.
REQ-019 The FSM SHALL advance only on out_valid=1; cycles with out_valid=0 SHALL leave all state and counters unchanged.
REQ-020 The FSM SHALL have the states IDLE, TRACK and LOCKED, with a hit counter hcnt and a miss counter mcnt.
REQ-021 In IDLE, on any hit: cand=first hit, hcnt=1, go to TRACK; if HOLD=1, go directly to LOCKED. With no hit, remain in IDLE.
REQ-022 In TRACK, if in_range[cand]=1: hcnt increments, and when it reaches HOLD the FSM goes to LOCKED. In_range[cand] is the bit checked, not the first hit.
REQ-023 In TRACK, if in_range[cand]=0 and another channel hits: cand=first hit, hcnt=1. If no channel hits: go to IDLE, hcnt=0.
REQ-024 In LOCKED, if in_range[cand]=1, mcnt=0. Otherwise mcnt increments, and at RELEASE the FSM goes to IDLE with hcnt=mcnt=0.
REQ-025 When the FSM leaves LOCKED, the block SHALL re-acquire from IDLE on the next valid sample, not on the releasing sample.
REQ-026 locked SHALL be a registered output, equal to 1 exactly when the state is LOCKED. It is updated in the cycle after the deciding out_valid, i.e. 2 cycles after that sample's in_valid.
REQ-027 lock_idx SHALL be registered and equal cand in TRACK and LOCKED, and 0 in IDLE.
REQ-028 The counters SHALL saturate and never wrap; counter width is clog2(max(HOLD,RELEASE)+1).
REQ-029 The block SHALL accept back-to-back in_valid every cycle without stalls and has no backpressure.

Reset
REQ-030 While resetn=0, the block SHALL hold out_valid=0, in_range=0, locked=0, lock_idx=0, state=IDLE and hcnt=mcnt=0, asynchronously.
REQ-031 Deassertion of resetn SHALL be synchronised to clk by the integrator. The first sample is accepted on the first rising edge with resetn=1.
REQ-032 Reset asserted mid-TRACK or mid-LOCKED SHALL discard any in-flight stage-1 sample.

Verification (W=16, N=4, HOLD=3, RELEASE=2, centers={400,300,200,100} for channels 3..0, tol=5)
REQ-033 Hold resetn low, toggle inputs -> all outputs remain 0. After release, out_valid stays 0 until the first in_valid.
REQ-034 Boundaries: x=105 -> in_range=0001; x=106 -> 0000; x=95 -> 0001; x=94 -> 0000. Each result appears 1 cycle after in_valid.
REQ-035 Lock and gaps: x=200 on three valid cycles with idle cycles between -> locked=1, lock_idx=1, 2 cycles after the third in_valid.
REQ-036 Hysteresis: once locked on channel 1, send x=0 then x=200 -> stays locked. Then x=0 twice -> locked=0 two cycles after the second.
REQ-037 Overflow and overlap:
- centers[0]=32765, tol=5, x=32767 -> bit0=1.
- centers[1]=-32766, x=-32768 -> bit1=1.
- centers[0]=100, centers[1]=104, x=102 -> in_range=0011, cand=0.
REQ-038 Candidate switch: sequence x=100, 100, 300, 300, 300 -> lock on channel 2 after the fifth sample. Then pulse resetn low -> all outputs are 0 immediately.

Source files
------------

// File: rtl/range_lock_detector.sv
// Per-channel window detector with a hit/miss hysteresis lock FSM.
// Stage 1 registers the window hits; the FSM consumes them one cycle later.
module range_lock_detector #(
    parameter int unsigned W       = 16,
    parameter int unsigned N       = 4,
    parameter int unsigned HOLD    = 8,
    parameter int unsigned RELEASE = 4,
    localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    input  logic [W-1:0]    x,
    input  logic [N*W-1:0]  centers,
    input  logic [W-1:0]    tol,
    output logic            out_valid,
    output logic [N-1:0]    in_range,
    output logic            locked,
    output logic [IW-1:0]   lock_idx
);

    localparam int unsigned MaxCnt = (HOLD > RELEASE) ? HOLD : RELEASE;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HoldC  = cnt_t'(HOLD);
    localparam cnt_t RelC   = cnt_t'(RELEASE);
    localparam cnt_t CntOne = cnt_t'(1);
    localparam cnt_t CntMax = {CW{1'b1}};

    typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

    // Two guard bits keep center +/- tol from wrapping at the W-bit extremes.
    logic signed [W+1:0] xe;
    logic signed [W+1:0] te;
    logic [N-1:0]        hit;

    assign xe = {{2{x[W-1]}}, x};
    assign te = {2'b00, tol};

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic signed [W+1:0] ce;
        logic signed [W+1:0] lo;
        logic signed [W+1:0] hi;
        assign ce     = {{2{centers[g*W+W-1]}}, centers[g*W +: W]};
        assign lo     = ce - te;
        assign hi     = ce + te;
        assign hit[g] = (xe >= lo) && (xe <= hi);
    end

    logic         out_valid_q;
    logic [N-1:0] in_range_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            in_range_q  <= '0;
        end else begin
            out_valid_q <= in_valid;
            in_range_q  <= in_valid ? hit : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign in_range  = in_range_q;

    logic [IW-1:0] first_idx;
    logic          any_hit;

    always_comb begin
        first_idx = '0;
        any_hit   = |in_range_q;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_range_q[i]) first_idx = IW'(i);
        end
    end

    state_e        state_q, state_d;
    logic [IW-1:0] cand_q, cand_d;
    cnt_t          hcnt_q, hcnt_d;
    cnt_t          mcnt_q, mcnt_d;
    cnt_t          hcnt_inc, mcnt_inc;
    logic          cand_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cand_q  <= '0;
            hcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            hcnt_q  <= hcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign cand_hit = in_range_q[cand_q];
    assign hcnt_inc = (hcnt_q == CntMax) ? hcnt_q : hcnt_q + CntOne;
    assign mcnt_inc = (mcnt_q == CntMax) ? mcnt_q : mcnt_q + CntOne;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        hcnt_d  = hcnt_q;
        mcnt_d  = mcnt_q;
        if (out_valid_q) begin
            unique case (state_q)
                StIdle: begin
                    if (any_hit) begin
                        cand_d  = first_idx;
                        hcnt_d  = CntOne;
                        mcnt_d  = '0;
                        state_d = (HOLD == 1) ? StLocked : StTrack;
                    end
                end
                StTrack: begin
                    if (cand_hit) begin
                        hcnt_d = hcnt_inc;
                        if (hcnt_inc >= HoldC) begin
                            state_d = StLocked;
                            mcnt_d  = '0;
                        end
                    end else if (any_hit) begin
                        cand_d = first_idx;
                        hcnt_d = CntOne;
                    end else begin
                        state_d = StIdle;
                        hcnt_d  = '0;
                    end
                end
                StLocked: begin
                    if (cand_hit) begin
                        mcnt_d = '0;
                    end else begin
                        mcnt_d = mcnt_inc;
                        // Release lands in IDLE; re-acquisition waits for the next sample.
                        if (mcnt_inc >= RelC) begin
                            state_d = StIdle;
                            hcnt_d  = '0;
                            mcnt_d  = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        locked   = (state_q == StLocked);
        lock_idx = (state_q == StIdle) ? '0 : cand_q;
    end

endmodule
